// File: rtl/hl_reset_sequencer.sv
// Board reset sequencer: PLL lock/settle, PHY reset pulse, then core reset release; debounced button restarts.
// Outputs are registered and change on the same edge as state_dbg; inputs add 2 cycles of synchronizer latency.
module hl_reset_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned SETTLE_CYCLES   = 50000,
  parameter int unsigned PHY_RST_CYCLES  = 500000,
  parameter int unsigned CORE_RST_CYCLES = 1024
) (
  input  logic       clk50mhz,
  input  logic       extreset,
  input  logic       btn_n,
  input  logic       pll_locked,
  output logic       core_reset,
  output logic       phy_reset_n,
  output logic       ready,
  output logic [2:0] state_dbg
);

  localparam int unsigned MAX_SP  = (SETTLE_CYCLES > PHY_RST_CYCLES) ? SETTLE_CYCLES : PHY_RST_CYCLES;
  localparam int unsigned SEQ_MAX = (MAX_SP > CORE_RST_CYCLES) ? MAX_SP : CORE_RST_CYCLES;
  localparam int unsigned CNT_W   = $clog2(SEQ_MAX) + 1;
  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PHY_LAST    = CNT_W'(PHY_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CORE_LAST   = CNT_W'(CORE_RST_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_HOLD      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_SETTLE    = 3'd2,
    S_PHY_RST   = 3'd3,
    S_CORE_RST  = 3'd4,
    S_RUN       = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_last, cnt_inc;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             db_q, db_d;
  logic [1:0]       btn_sync_q, btn_sync_d;
  logic [1:0]       lock_sync_q, lock_sync_d;
  logic             core_reset_q, core_reset_d;
  logic             phy_reset_n_q, phy_reset_n_d;
  logic             ready_q, ready_d;
  logic             btn_press;
  logic             lock_ok;

  assign lock_ok = lock_sync_q[1];

  // Debouncer: a flip needs DEBOUNCE_CYCLES consecutive samples opposite to the held value.
  always_comb begin
    btn_sync_d  = {btn_sync_q[0], btn_n};
    lock_sync_d = {lock_sync_q[0], pll_locked};
    db_d        = db_q;
    db_cnt_d    = '0;
    btn_press   = 1'b0;
    if (btn_sync_q[1] != db_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_d      = ~db_q;
        btn_press = db_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  always_comb begin
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    case (state_q)
      S_SETTLE:  cnt_last = SETTLE_LAST;
      S_PHY_RST: cnt_last = PHY_LAST;
      default:   cnt_last = CORE_LAST;
    endcase
  end

  // Lock loss outranks the button, which outranks the dwell counter finishing.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_HOLD:      state_d = S_WAIT_LOCK;
      S_WAIT_LOCK: if (lock_ok) state_d = S_SETTLE;
      S_SETTLE, S_PHY_RST, S_CORE_RST: begin
        if (!lock_ok || btn_press) begin
          state_d = S_WAIT_LOCK;
        end else if (cnt_q == cnt_last) begin
          case (state_q)
            S_SETTLE:  state_d = S_PHY_RST;
            S_PHY_RST: state_d = S_CORE_RST;
            default:   state_d = S_RUN;
          endcase
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RUN:       if (!lock_ok || btn_press) state_d = S_WAIT_LOCK;
      default:     state_d = S_HOLD;
    endcase
    core_reset_d  = (state_d != S_RUN);
    phy_reset_n_d = (state_d == S_CORE_RST) || (state_d == S_RUN);
    ready_d       = (state_d == S_RUN);
  end

  always_ff @(posedge clk50mhz) begin
    btn_sync_q  <= btn_sync_d;
    lock_sync_q <= lock_sync_d;
    if (extreset) begin
      state_q       <= S_HOLD;
      cnt_q         <= '0;
      db_q          <= 1'b1;
      db_cnt_q      <= '0;
      core_reset_q  <= 1'b1;
      phy_reset_n_q <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      db_q          <= db_d;
      db_cnt_q      <= db_cnt_d;
      core_reset_q  <= core_reset_d;
      phy_reset_n_q <= phy_reset_n_d;
      ready_q       <= ready_d;
    end
  end

  assign core_reset  = core_reset_q;
  assign phy_reset_n = phy_reset_n_q;
  assign ready       = ready_q;
  assign state_dbg   = state_q;

endmodule
